// File: rtl/myrisc16_hex_uart_pkg.sv
// rtl/myrisc16_hex_uart_pkg.sv - shared state encoding, message constants and hex helper
package myrisc16_hex_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int         MSG_LEN  = 6;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/myrisc16_hex_uart_tx_byte.sv
// rtl/myrisc16_hex_uart_tx_byte.sv - UART byte serialiser, 8N1 (8E1 with MYRISC16_HEX_UART_PARITY_EN)
module uart_tx_byte
    import myrisc16_hex_uart_pkg::*;
#(
    parameter int DIVISOR = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       tx,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
`ifdef MYRISC16_HEX_UART_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        bit_end;

    assign bit_end = (baud_q == 16'(DIVISOR - 1));
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? 16'd0 : baud_q + 16'd1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
`ifdef MYRISC16_HEX_UART_PARITY_EN
        parity_d = parity_q;
`endif
        s_tready = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d   = 16'd0;
                s_tready = 1'b1;
                if (s_tvalid) begin
                    state_d  = START;
                    shreg_d  = s_tdata;
                    bit_d    = 3'd0;
`ifdef MYRISC16_HEX_UART_PARITY_EN
                    parity_d = ^s_tdata;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef MYRISC16_HEX_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
`ifdef MYRISC16_HEX_UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Accepting here, on the last stop-bit clock, keeps frames back-to-back.
                s_tready = bit_end;
                if (bit_end) begin
                    if (s_tvalid) begin
                        state_d  = START;
                        shreg_d  = s_tdata;
                        bit_d    = 3'd0;
`ifdef MYRISC16_HEX_UART_PARITY_EN
                        parity_d = ^s_tdata;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = shreg_q[0];
`ifdef MYRISC16_HEX_UART_PARITY_EN
            PARITY: tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            baud_q   <= 16'd0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'd0;
`ifdef MYRISC16_HEX_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
`ifdef MYRISC16_HEX_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: rtl/myrisc16_hex_uart.sv
// rtl/myrisc16_hex_uart.sv - sends each new 16-bit port value as "XXXX\r\n"; parity via MYRISC16_HEX_UART_PARITY_EN
module myrisc16_hex_uart
    import myrisc16_hex_uart_pkg::*;
#(
    parameter int DIVISOR = 104
) (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic [15:0] in_data,
    output logic        out_tx,
    output logic        out_busy
);

    logic [15:0] data_q, data_d;
    logic [15:0] last_sent_q, last_sent_d;
    logic [15:0] snap_q, snap_d;
    logic [2:0]  idx_q, idx_d;

    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_busy;

    function automatic logic [7:0] msg_byte(input logic [15:0] v, input logic [2:0] idx);
        case (idx)
            3'd0:    return nibble_to_ascii(v[15:12]);
            3'd1:    return nibble_to_ascii(v[11:8]);
            3'd2:    return nibble_to_ascii(v[7:4]);
            3'd3:    return nibble_to_ascii(v[3:0]);
            3'd4:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

    always_comb begin
        data_d      = in_data;
        last_sent_d = last_sent_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        tx_valid    = 1'b0;
        tx_data     = 8'd0;
        if (tx_busy) begin
            // Next byte of the current message, taken at the end of the stop bit.
            tx_valid = (idx_q < 3'(MSG_LEN - 1));
            tx_data  = msg_byte(snap_q, idx_q + 3'd1);
        end else begin
            // Changes seen mid-message collapse into this single comparison.
            tx_valid = (data_q != last_sent_q);
            tx_data  = msg_byte(data_q, 3'd0);
        end
        if (tx_valid && tx_ready) begin
            if (tx_busy) begin
                idx_d = idx_q + 3'd1;
            end else begin
                snap_d      = data_q;
                last_sent_d = data_q;
                idx_d       = 3'd0;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            data_q      <= 16'd0;
            last_sent_q <= 16'd0;
            snap_q      <= 16'd0;
            idx_q       <= 3'd0;
        end else begin
            data_q      <= data_d;
            last_sent_q <= last_sent_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
        end
    end

    uart_tx_byte #(
        .DIVISOR (DIVISOR)
    ) u_tx (
        .clk      (in_clock),
        .resetn   (in_reset),
        .s_tdata  (tx_data),
        .s_tvalid (tx_valid),
        .s_tready (tx_ready),
        .tx       (out_tx),
        .busy     (tx_busy)
    );

    assign out_busy = tx_busy;

endmodule
